// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants, slice-width helper and stage record for pipe_cla_adder
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 2;
  localparam int DEF_GROUP  = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Stage record at the default width; the adder declares the same layout at its own WIDTH.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 carry;
    logic                 msb_cin;
  } stage_t;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit carry-lookahead adder with group propagate/generate outputs
module cla_group
  import pipe_adder_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] pi;
  logic [GROUP-1:0] gi;
  logic [GROUP:0]   c;
  logic             run_g;
  logic             run_p;

  assign pi = a ^ b;
  assign gi = a & b;

  // Each carry is a flat sum of products so no carry waits on the one below it.
  always_comb begin
    c     = '0;
    c[0]  = ci;
    run_g = 1'b0;
    run_p = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      run_g = gi[i];
      run_p = pi[i];
      for (int j = i - 1; j >= 0; j--) begin
        run_g = run_g | (run_p & gi[j]);
        run_p = run_p & pi[j];
      end
      c[i+1] = run_g | (run_p & ci);
    end
  end

  // Kept apart from the carry block so group p/g never depend on ci.
  always_comb begin
    g = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      g = gi[i] | (pi[i] & g);
    end
  end

  assign p  = &pi;
  assign s  = pi ^ c[GROUP-1:0];
  assign co = c[GROUP];

endmodule

// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage
module pipe_cla_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int GROUP  = DEF_GROUP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_co,
  output logic             o_ovf
);

  localparam int S    = slice_width(WIDTH, STAGES);
  localparam int NG   = S / GROUP;
  localparam int LAST = STAGES - 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic             msb_cin;
  } stage_reg_t;

  if (WIDTH % (STAGES * GROUP) != 0) begin : g_bad_cfg
    $error("pipe_cla_adder: WIDTH must be a multiple of STAGES*GROUP");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_reg_t       r;
    logic             adv;
    logic             vin;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_next;
    logic             cin;
    logic             cout;
    logic             c_acc;
    logic             msb_cin;
    logic [S-1:0]     a_sl;
    logic [S-1:0]     b_sl;
    logic [S-1:0]     s_slice;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gci;
    logic [NG-1:0]    unused_co;

    // B is inverted once at entry; the stored b field is already B'.
    if (k == 0) begin : g_entry
      assign vin    = i_valid;
      assign a_in   = i_data1;
      assign b_in   = i_data2 ^ {WIDTH{i_sub}};
      assign cin    = i_sub;
      assign sum_in = '0;
    end else begin : g_body
      assign vin    = g_stage[k-1].r.valid;
      assign a_in   = g_stage[k-1].r.a;
      assign b_in   = g_stage[k-1].r.b;
      assign cin    = g_stage[k-1].r.carry;
      assign sum_in = g_stage[k-1].r.sum;
    end

    if (k == LAST) begin : g_tail
      logic unused_ops;
      assign adv        = !r.valid || i_ready;
      assign unused_ops = ^{r.a, r.b};
    end else begin : g_link
      logic unused_msb;
      assign adv        = !r.valid || g_stage[k+1].adv;
      assign unused_msb = r.msb_cin;
    end

    assign a_sl = a_in[k*S +: S];
    assign b_sl = b_in[k*S +: S];

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a  (a_sl[j*GROUP +: GROUP]),
        .b  (b_sl[j*GROUP +: GROUP]),
        .ci (gci[j]),
        .s  (s_slice[j*GROUP +: GROUP]),
        .co (unused_co[j]),
        .p  (gp[j]),
        .g  (gg[j])
      );
    end

    // Second lookahead level: group carries come from group p/g, not from group co.
    always_comb begin
      c_acc = cin;
      gci   = '0;
      for (int j = 0; j < NG; j++) begin
        gci[j] = c_acc;
        c_acc  = gg[j] | (gp[j] & c_acc);
      end
      cout = c_acc;
    end

    assign msb_cin = s_slice[S-1] ^ a_sl[S-1] ^ b_sl[S-1];

    always_comb begin
      sum_next          = sum_in;
      sum_next[k*S +: S] = s_slice;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r <= '0;
      end else if (adv) begin
        r.valid <= vin;
        if (vin) begin
          r.sum     <= sum_next;
          r.a       <= a_in;
          r.b       <= b_in;
          r.carry   <= cout;
          r.msb_cin <= msb_cin;
        end
      end
    end
  end

  assign o_ready = g_stage[0].adv;
  assign o_valid = g_stage[LAST].r.valid;
  assign o_sum   = g_stage[LAST].r.sum;
  assign o_co    = g_stage[LAST].r.carry;
  assign o_ovf   = g_stage[LAST].r.msb_cin ^ g_stage[LAST].r.carry;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb/tb_pipe_cla_adder.sv - scoreboard bench for pipe_cla_adder (WIDTH=32, STAGES=2)
module tb_pipe_cla_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int GROUP  = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_sub = 1'b0;
  logic             i_ready = 1'b1;
  logic [WIDTH-1:0] i_data1 = '0;
  logic [WIDTH-1:0] i_data2 = '0;
  logic             o_ready;
  logic             o_valid;
  logic             o_co;
  logic             o_ovf;
  logic [WIDTH-1:0] o_sum;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    bit               lat;
    int               cyc;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
  } vec_t;

  exp_t             sb[$];
  exp_t             mon_e;
  exp_t             rnd_e;
  vec_t             vecs[7];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc = 0;
  int               n_out = 0;
  int               n_exp_out = 0;
  int               n_acc = 0;
  int               base;
  logic             held = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic             held_co;
  logic             held_ovf;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             rs;

  pipe_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(GROUP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data1 (i_data1),
    .i_data2 (i_data2),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_co    (o_co),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    exp_t             e;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    e.sum = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    e.ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    e.lat = 1'b0;
    e.cyc = 0;
    return e;
  endfunction

  // Called at posedge+1; holds the operands until accepted, then returns at the next posedge+1.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                      input logic [WIDTH-1:0] es, input logic eco, input logic eovf,
                      input bit lat);
    exp_t e;
    int   w;
    i_valid = 1'b1;
    i_data1 = a;
    i_data2 = b;
    i_sub   = sub;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (o_ready) begin
      e.sum = es;
      e.co  = eco;
      e.ovf = eovf;
      e.lat = lat;
      e.cyc = cyc;
      sb.push_back(e);
      n_acc++;
      n_exp_out++;
    end else begin
      check("accept_timeout", 64'(o_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && o_valid && !i_ready) begin
      if (held) begin
        check("hold_sum", 64'(o_sum), 64'(held_sum));
        check("hold_co", 64'(o_co), 64'(held_co));
        check("hold_ovf", 64'(o_ovf), 64'(held_ovf));
      end
      held     = 1'b1;
      held_sum = o_sum;
      held_co  = o_co;
      held_ovf = o_ovf;
    end else begin
      held = 1'b0;
    end
    if (reset_n && o_valid && i_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("spurious_out", 64'(o_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sum", 64'(o_sum), 64'(mon_e.sum));
        check("co", 64'(o_co), 64'(mon_e.co));
        check("ovf", 64'(o_ovf), 64'(mon_e.ovf));
        if (mon_e.lat) check("latency", 64'(cyc - mon_e.cyc), 64'(STAGES));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0004, 32'h0000_0010, 1'b0, 32'h0000_0014, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};

    #3;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_sum", 64'(o_sum), 64'd0);
    check("rst_co", 64'(o_co), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back to back at full rate.
    for (int i = 0; i < 7; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].co, vecs[i].ovf, 1'b1);
    drain();

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rnd_e = model(ra, rb, rs);
      send(ra, rb, rs, rnd_e.sum, rnd_e.co, rnd_e.ovf, 1'b1);
    end
    drain();

    // Back-pressure: stall the consumer for 4 cycles once the pipe is full.
    base = n_acc;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(WIDTH'(i), 32'h100, 1'b0, WIDTH'(i + 32'h100), 1'b0, 1'b0, 1'b0);
      end
      begin
        int w;
        w = 0;
        while (n_acc < base + 3 && w < 100) begin
          @(posedge clk);
          w++;
        end
        #1 i_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_ready", 64'(o_ready), 64'd0);
        end
        @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    send(32'h1234_5678, 32'h0000_0001, 1'b0, 32'h1234_5679, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_sum", 64'(o_sum), 64'd0);
    check("midrst_co", 64'(o_co), 64'd0);
    n_exp_out -= sb.size();
    sb.delete();
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(o_valid), 64'd0);
    check("post_rst_ready", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    send(32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0, 1'b1);
    drain();

    check("out_count", 64'(n_out), 64'(n_exp_out));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
Name: pipe_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the pipeline CPU datapath (branch target, address and ALU add paths).
- Splits a WIDTH-bit add into STAGES slices, one slice per cycle. The carry is registered between slices.
- Operands are skewed through the pipe so a full-width result, carry-out and signed overflow emerge STAGES cycles after acceptance.
- Valid/ready handshakes on both sides support hazard stalls.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 2, pipeline stages; each adds WIDTH/STAGES bits.
- GROUP, 4, CLA group width inside a slice; WIDTH/STAGES must be a multiple of GROUP.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operands present.
- o_ready  output  1  adder can accept this cycle.
- i_data1  input  WIDTH  operand A.
- i_data2  input  WIDTH  operand B.
- i_sub  input  1  1 = A - B, 0 = A + B.
- o_valid  output  1  result present.
- i_ready  input  1  consumer accepts result.
- o_sum  output  WIDTH  result.
- o_co  output  1  carry-out of MSB (for subtract: 1 = no borrow).
- o_ovf  output  1  signed overflow.

Behaviour:
- Reset (async, reset_n=0): all stage valid bits clear; o_valid=0, o_sum=0, o_co=0, o_ovf=0, all data/carry registers 0. Takes effect immediately, including mid-operation; in-flight ops are discarded. o_ready=1 while in reset is don't-care; it is 1 from the first cycle after reset release.
- Slice width S = WIDTH/STAGES. Stage k (k = 0..STAGES-1) adds bits [k*S +: S] of A and B' (B' = B ^ {WIDTH{i_sub}}) with the carry-in below:
  - Stage 0 carry-in = i_sub.
  - Stage k>0 carry-in = registered carry-out of stage k-1.
- Each stage register holds:
  - valid bit;
  - completed lower sum slices;
  - not-yet-added upper operand slices;
  - carry;
  - carry into the current top bit (for overflow).
  - The sub flag is folded into B' at entry and is not carried further.
- Stage k's slice is a combinational CLA built from GROUP-bit lookahead groups.
- Latency: accept at edge N (i_valid & o_ready) -> o_valid=1 after edge N+STAGES-1 with no stall, i.e. visible STAGES cycles after i_valid was first presented. Throughput is 1 op/cycle.
- Handshake:
  - Stage k advances when it is empty or stage k+1 advances; the last stage advances when i_ready=1 or it is empty.
  - o_ready = stage-0 advance condition (combinational from i_ready through the chain).
  - Held stages keep all contents stable; o_sum/o_co/o_ovf stay stable while o_valid=1 and i_ready=0.
  - A transfer with i_valid=1 and o_ready=0 is not accepted; the source must hold its operands.
- Simultaneous accept and emit in the same cycle when full with i_ready=1: both happen; no bubble is inserted.
- Outputs:
  - o_co = carry-out of bit WIDTH-1.
  - o_ovf = carry into bit WIDTH-1 XOR o_co.
  - o_sum wraps modulo 2^WIDTH.
- Outputs are registered (final stage register); no combinational path from i_data* to outputs.
- STAGES=1 degenerates to a single registered CLA with 1-cycle latency.
- Elaboration error if WIDTH % (STAGES*GROUP) != 0.

Decomposition:
- Shared package pipe_adder_pkg: default WIDTH/STAGES/GROUP constants, the slice-width function, and the stage register struct (valid, sum, upper A, upper B', carry, msb_cin).
- One sub-module, cla_group: GROUP-bit generate/propagate lookahead adder with ci, s, co, and group p/g outputs. It is instantiated S/GROUP times per stage and chained within the slice.

Test Plan:
- Basic add (WIDTH=32, STAGES=2): A=0x0000_0004, B=0x0000_0010, sub=0 -> o_sum=0x0000_0014, o_co=0, o_ovf=0, o_valid 2 cycles after accept.
- Cross-slice carry and wrap: 0xFFFF_FFFF + 0x0000_0001 -> o_sum=0x0000_0000, o_co=1, o_ovf=0. Repeat with 0x0000_FFFF + 1 -> 0x0001_0000, proving the inter-stage carry.
- Signed overflow:
  - 0x7FFF_FFFF + 1 -> 0x8000_0000, o_ovf=1, o_co=0.
  - sub 0x8000_0000 - 1 -> 0x7FFF_FFFF, o_ovf=1, o_co=1.
- Subtract with borrow: 5 - 7 -> 0xFFFF_FFFE, o_co=0, o_ovf=0. Then 7 - 5 -> 0x0000_0002, o_co=1.
- Back-pressure: stream A=1..6, B=0x100, with i_ready=0 for 4 cycles mid-stream -> o_ready drops after 2 ops are held, outputs stay stable, results 0x101..0x106 emerge in order with none lost or duplicated; full-rate accept+emit when i_ready=1.
- Reset mid-operation: 2 ops in flight, reset_n pulsed low between edges -> o_valid=0 and o_sum=0 immediately. After release a new op 3+4 yields 0x7 with correct latency and no stale output.
